// File: rtl/core_pkg.sv
// Shared register-file defaults and the architectural register address type.
package core_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/rf_read_port.sv
// One read port: array mux, same-cycle write bypass, zero-register force and scoreboard lookup.
module rf_read_port #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic [NREG-1:0][XLEN-1:0] mem,
  input  logic [NREG-1:0]           busy,
  input  logic [AW-1:0]             rs,
  input  logic                      we,
  input  logic [AW-1:0]             rd,
  input  logic [XLEN-1:0]           wd,
  input  logic                      reserve,
  input  logic [AW-1:0]             reserve_rd,
  output logic [XLEN-1:0]           operand,
  output logic                      busy_rd
);

  logic rs_zero;
  logic hit;

  assign rs_zero = (rs == '0);
  assign hit     = (BYPASS != 0) && we && (rd == rs) && !rs_zero;

  always_comb begin
    operand = mem[rs];
    busy_rd = busy[rs];
    if (rs_zero) begin
      operand = '0;
      busy_rd = 1'b0;
    end else if (hit) begin
      // A bypassed write retires the old producer unless a new one reserves it now.
      operand = wd;
      busy_rd = reserve && (reserve_rd == rs);
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass and a pending-write scoreboard.
module regfile_mp
  import core_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      regwrite_i,
  input  logic [AW-1:0]             rd_i,
  input  logic [XLEN-1:0]           wd_i,
  input  logic                      reserve_i,
  input  logic [AW-1:0]             reserve_rd_i,
  input  logic [NRD-1:0][AW-1:0]    rs_i,
  output logic [NRD-1:0][XLEN-1:0]  operand_o,
  output logic [NRD-1:0]            busy_o,
  output logic                      busy_any_o
);

  logic [NREG-1:0][XLEN-1:0] mem_q;
  logic [NREG-1:0]           busy_q;
  logic                      we;
  logic                      res;

  // Reset masks both update requests so the bypass path also ignores them.
  assign we  = regwrite_i && !reset_i && (rd_i != '0);
  assign res = reserve_i && !reset_i && (reserve_rd_i != '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      if (we) begin
        mem_q[rd_i]  <= wd_i;
        busy_q[rd_i] <= 1'b0;
      end
      if (res) begin
        busy_q[reserve_rd_i] <= 1'b1;
      end
    end
  end

  assign busy_any_o = |busy_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    rf_read_port #(
      .XLEN   (XLEN),
      .NREG   (NREG),
      .BYPASS (BYPASS)
    ) u_port (
      .mem        (mem_q),
      .busy       (busy_q),
      .rs         (rs_i[p]),
      .we         (we),
      .rd         (rd_i),
      .wd         (wd_i),
      .reserve    (res),
      .reserve_rd (reserve_rd_i),
      .operand    (operand_o[p]),
      .busy_rd    (busy_o[p])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: one bypassing and one non-bypassing instance share the same stimulus.
module tb_regfile_mp;
  import core_pkg::*;

  logic                clk_i = 1'b0;
  logic                reset_i;
  logic                regwrite_i;
  reg_addr_t           rd_i;
  logic [31:0]         wd_i;
  logic                reserve_i;
  reg_addr_t           reserve_rd_i;
  logic [1:0][4:0]     rs_i;
  logic [1:0][31:0]    op_b1, op_b0;
  logic [1:0]          busy_b1, busy_b0;
  logic                any_b1, any_b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1)) u_b1 (
    .clk_i(clk_i), .reset_i(reset_i), .regwrite_i(regwrite_i), .rd_i(rd_i), .wd_i(wd_i),
    .reserve_i(reserve_i), .reserve_rd_i(reserve_rd_i), .rs_i(rs_i),
    .operand_o(op_b1), .busy_o(busy_b1), .busy_any_o(any_b1));

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0)) u_b0 (
    .clk_i(clk_i), .reset_i(reset_i), .regwrite_i(regwrite_i), .rd_i(rd_i), .wd_i(wd_i),
    .reserve_i(reserve_i), .reserve_rd_i(reserve_rd_i), .rs_i(rs_i),
    .operand_o(op_b0), .busy_o(busy_b0), .busy_any_o(any_b0));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge, then leave 1ns so inputs change away from the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    regwrite_i = 1'b0;
    reserve_i  = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; regwrite_i = 1'b0; rd_i = '0; wd_i = '0;
    reserve_i = 1'b0; reserve_rd_i = '0; rs_i = '0;
    tick(); tick();
    reset_i = 1'b0;

    // Reset state on every address, both ports, both instances.
    for (int r = 0; r < 32; r++) begin
      rs_i[0] = 5'(r); rs_i[1] = 5'(31 - r);
      #1;
      check("rst_op", op_b1[0] | op_b1[1] | op_b0[0] | op_b0[1], 32'h0);
      check("rst_busy", {28'h0, busy_b1, busy_b0}, 32'h0);
    end
    check("rst_any", {30'h0, any_b1, any_b0}, 32'h0);

    // Write latency with and without bypass; identical rs on both ports.
    rs_i[0] = 5'd5; rs_i[1] = 5'd5;
    regwrite_i = 1'b1; rd_i = 5'd5; wd_i = 32'hDEADBEEF;
    #1;
    check("byp_same_cyc", op_b1[0], 32'hDEADBEEF);
    check("byp_port1", op_b1[1], 32'hDEADBEEF);
    check("nobyp_old", op_b0[0], 32'h0);
    tick(); idle(); #1;
    check("nobyp_next", op_b0[0], 32'hDEADBEEF);
    check("nobyp_port1", op_b0[1], 32'hDEADBEEF);
    check("byp_hold", op_b1[0], 32'hDEADBEEF);

    // Register zero: writes and reserves discarded.
    regwrite_i = 1'b1; rd_i = 5'd0; wd_i = 32'hFFFFFFFF; rs_i[0] = 5'd0;
    #1;
    check("r0_byp", op_b1[0], 32'h0);
    tick(); idle(); #1;
    check("r0_read", op_b1[0] | op_b0[0], 32'h0);
    reserve_i = 1'b1; reserve_rd_i = 5'd0;
    tick(); idle(); #1;
    check("r0_rsv_any", {30'h0, any_b1, any_b0}, 32'h0);

    // Reserve then write retires the pending bit.
    reserve_i = 1'b1; reserve_rd_i = 5'd7; rs_i[0] = 5'd7;
    #1;
    check("rsv_same_cyc", {30'h0, busy_b1[0], busy_b0[0]}, 32'h0);
    tick(); idle(); #1;
    check("rsv_busy", {30'h0, busy_b1[0], busy_b0[0]}, 32'h3);
    check("rsv_any", {30'h0, any_b1, any_b0}, 32'h3);
    regwrite_i = 1'b1; rd_i = 5'd7; wd_i = 32'h77;
    #1;
    check("wr7_busy_b1", {31'h0, busy_b1[0]}, 32'h0);
    check("wr7_busy_b0", {31'h0, busy_b0[0]}, 32'h1);
    check("wr7_any_unbyp", {30'h0, any_b1, any_b0}, 32'h3);
    tick(); idle(); #1;
    check("wr7_any_after", {30'h0, any_b1, any_b0}, 32'h0);
    check("wr7_busy_after", {30'h0, busy_b1[0], busy_b0[0]}, 32'h0);
    check("wr7_data", op_b0[0], 32'h77);

    // Reserve and write to the same register in one cycle: reserve wins.
    reserve_i = 1'b1; reserve_rd_i = 5'd9;
    regwrite_i = 1'b1; rd_i = 5'd9; wd_i = 32'h1234; rs_i[0] = 5'd9;
    #1;
    check("rw9_byp_busy", {31'h0, busy_b1[0]}, 32'h1);
    check("rw9_byp_op", op_b1[0], 32'h1234);
    tick(); idle(); #1;
    check("rw9_op", op_b1[0] ^ op_b0[0], 32'h0);
    check("rw9_op_val", op_b0[0], 32'h1234);
    check("rw9_busy", {30'h0, busy_b1[0], busy_b0[0]}, 32'h3);
    regwrite_i = 1'b1; rd_i = 5'd9; wd_i = 32'h55;
    tick(); idle(); #1;
    check("rw9_clear", {30'h0, any_b1, any_b0}, 32'h0);

    // Reset mid-operation drops data and reservations; requests in the reset cycle ignored.
    regwrite_i = 1'b1; rd_i = 5'd3; wd_i = 32'hA5A5A5A5;
    reserve_i = 1'b1; reserve_rd_i = 5'd4;
    tick(); idle();
    rs_i[0] = 5'd3; rs_i[1] = 5'd4;
    #1;
    check("pre_rst_op", op_b0[0], 32'hA5A5A5A5);
    check("pre_rst_busy4", {30'h0, busy_b1[1], busy_b0[1]}, 32'h3);
    reset_i = 1'b1;
    regwrite_i = 1'b1; rd_i = 5'd3; wd_i = 32'h1111;
    reserve_i = 1'b1; reserve_rd_i = 5'd6;
    tick(); idle(); reset_i = 1'b0;
    rs_i[1] = 5'd6;
    #1;
    check("post_rst_op3", op_b1[0] | op_b0[0], 32'h0);
    check("post_rst_any", {30'h0, any_b1, any_b0}, 32'h0);
    check("post_rst_busy6", {30'h0, busy_b1[1], busy_b0[1]}, 32'h0);
    regwrite_i = 1'b1; rd_i = 5'd4; wd_i = 32'h44; rs_i[1] = 5'd4;
    tick(); idle(); #1;
    check("post_rst_wr4", op_b0[1], 32'h44);
    check("post_rst_wr4_busy", {30'h0, busy_b1[1], busy_b0[1]}, 32'h0);

    // Address decode sweep: distinct value in every register, read back crossed.
    for (int r = 1; r < 32; r++) begin
      regwrite_i = 1'b1; rd_i = 5'(r); wd_i = 32'(r) * 32'h01010101;
      tick();
    end
    idle();
    for (int r = 1; r < 32; r++) begin
      rs_i[0] = 5'(r); rs_i[1] = 5'(32 - r);
      #1;
      check("sweep_p0", op_b1[0], 32'(r) * 32'h01010101);
      check("sweep_p1", op_b0[1], 32'(32 - r) * 32'h01010101);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
